button_debounce_pulse: RTL and testbench

Debounces and edge-qualifies the 5-bit button word from the button press decoder. It emits exactly one single-cycle pulse per accepted press, along with a registered 2-bit button code. It sits between the decoder and the calculator control logic, so downstream logic sees one clean event per switch actuation. Its input comes from slide switches through combinational decode, so it is treated as asynchronous and synchronised here.

---
 rtl/button_debounce_pulse.sv | 80 ++++++++
 tb/tb_button_debounce_pulse.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_pulse.sv
// button_debounce_pulse: synchronises and debounces the decoder button word,
// emitting one single-cycle pulse and a registered code per accepted press.
module button_debounce_pulse #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic       newClock,
    input  logic       reset,
    input  logic [4:0] buttonInformation,
    output logic       buttonPulse,
    output logic [1:0] buttonCode,
    output logic       buttonHeld
);
    typedef enum logic [2:0] {IDLE, ARMING, PRESSED, HELD, RELEASING} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [2:0]       sync1, sync2;
    logic [1:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic             unused_bits;

    // Bits 3:2 carry no information, so only {valid, index} is synchronised.
    assign unused_bits = ^buttonInformation[3:2];

    always_ff @(posedge newClock) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            cand        <= '0;
            cnt         <= '0;
            state       <= IDLE;
            buttonPulse <= 1'b0;
            buttonCode  <= '0;
            buttonHeld  <= 1'b0;
        end else begin
            sync1 <= {buttonInformation[4], buttonInformation[1:0]};
            sync2 <= sync1;
            case (state)
                IDLE: if (sync2[2]) begin
                    state <= ARMING;
                    cand  <= sync2[1:0];
                    cnt   <= ONE;
                end
                ARMING: if (!sync2[2]) begin
                    state <= IDLE;
                end else if (sync2[1:0] != cand) begin
                    cand <= sync2[1:0];
                    cnt  <= ONE;
                end else if (cnt == LAST) begin
                    state       <= PRESSED;
                    buttonPulse <= 1'b1;
                    buttonCode  <= cand;
                    buttonHeld  <= 1'b1;
                end else begin
                    cnt <= cnt + ONE;
                end
                PRESSED: begin
                    state       <= HELD;
                    buttonPulse <= 1'b0;
                end
                HELD: if (!sync2[2]) begin
                    state <= RELEASING;
                    cnt   <= ONE;
                end
                RELEASING: if (sync2[2]) begin
                    state <= HELD;
                end else if (cnt == LAST) begin
                    state      <= IDLE;
                    buttonHeld <= 1'b0;
                end else begin
                    cnt <= cnt + ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_button_debounce_pulse.sv
// tb_button_debounce_pulse: table vectors, directed corner sequences and random
// stimulus checked against a run-length reference model.
module tb_button_debounce_pulse;
    localparam int STABLE = 4;
    localparam int FREE = 0, JUSTP = 1, HOLD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] info = '0;
    logic       buttonPulse, buttonHeld;
    logic [1:0] buttonCode;

    button_debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .newClock(clk),
        .reset(reset),
        .buttonInformation(info),
        .buttonPulse(buttonPulse),
        .buttonCode(buttonCode),
        .buttonHeld(buttonHeld)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    int pcount;
    logic [1:0] pcodes[$];

    // Reference: a press is accepted once STABLE consecutive sampled words
    // carry the same valid code; a release once STABLE consecutive samples are
    // invalid. The sample seen at an edge is the input applied two edges earlier.
    logic [4:0] m_p1, m_p2, m_s;
    int         m_mode, m_run;
    logic [1:0] m_rcode;
    logic       m_pulse, m_held;
    logic [1:0] m_code;

    task automatic model(input logic r, input logic [4:0] x);
        if (r) begin
            m_p1 = '0; m_p2 = '0; m_mode = FREE; m_run = 0; m_rcode = '0;
            m_pulse = 0; m_held = 0; m_code = '0;
        end else begin
            m_s = m_p2; m_p2 = m_p1; m_p1 = x;
            m_pulse = 0;
            if (m_mode == FREE) begin
                if (m_s[4]) begin
                    m_run = (m_run > 0 && m_s[1:0] == m_rcode) ? m_run + 1 : 1;
                    m_rcode = m_s[1:0];
                    if (m_run == STABLE) begin
                        m_pulse = 1; m_code = m_rcode; m_held = 1; m_mode = JUSTP; m_run = 0;
                    end
                end else m_run = 0;
            end else if (m_mode == JUSTP) begin
                m_mode = HOLD; m_run = 0;
            end else begin
                m_run = m_s[4] ? 0 : m_run + 1;
                if (m_run == STABLE) begin
                    m_held = 0; m_mode = FREE; m_run = 0;
                end
            end
        end
    endtask

    task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] x);
        reset = r;
        info = x;
        @(posedge clk);
        model(r, x);
        @(negedge clk);
        cmp("model_pulse", {7'd0, buttonPulse}, {7'd0, m_pulse});
        cmp("model_code", {6'd0, buttonCode}, {6'd0, m_code});
        cmp("model_held", {7'd0, buttonHeld}, {7'd0, m_held});
        if (buttonPulse === 1'b1) begin
            pcount++;
            pcodes.push_back(buttonCode);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'b0);
        pcount = 0;
        pcodes.delete();
    endtask

    // Reset is applied while 10001 is held; the press must re-arm from scratch.
    task automatic reset_then_press(input string n);
        int first;
        first = 0;
        step(1'b1, 5'b10001);
        cmp({n, "_out_after_reset"}, {5'd0, buttonPulse, buttonCode}, 8'd0);
        cmp({n, "_held_after_reset"}, {7'd0, buttonHeld}, 8'd0);
        pcount = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 5'b10001);
            if (buttonPulse === 1'b1 && first == 0) first = i;
        end
        cmp({n, "_latency"}, 8'(first), 8'(STABLE + 2));
        cmp({n, "_pulses"}, 8'(pcount), 8'd1);
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] in;
        logic       pulse;
        logic [1:0] code;
        logic       held;
    } vec_t;
    vec_t tbl[16];

    logic [4:0] v;
    int len;

    initial begin
        // Clean press: entry i is the input before edge i and the outputs after it.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{rst: (i == 0), in: (i >= 1 && i <= 8) ? 5'b10010 : 5'b0,
                       pulse: (i == 6), code: (i >= 6) ? 2'b10 : 2'b00,
                       held: (i >= 6 && i < 14)};
        pcount = 0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].in);
            cmp("tbl_pulse", {7'd0, buttonPulse}, {7'd0, tbl[i].pulse});
            cmp("tbl_code", {6'd0, buttonCode}, {6'd0, tbl[i].code});
            cmp("tbl_held", {7'd0, buttonHeld}, {7'd0, tbl[i].held});
        end

        // Bounce on press: valid never lasts long enough.
        step(1'b1, 5'b0);
        quiet(3);
        for (int i = 0; i < 12; i++) step(1'b0, (i % 4 < 2) ? 5'b10001 : 5'b0);
        quiet(0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 5'b0);
        end
        cmp("bounce_pulses", 8'(pcount), 8'd0);
        cmp("bounce_code", {6'd0, buttonCode}, 8'd0);

        // Code change while arming.
        quiet(4);
        step(1'b0, 5'b10000);
        step(1'b0, 5'b10000);
        for (int i = 0; i < 12; i++) step(1'b0, 5'b10011);
        cmp("codechg_pulses", 8'(pcount), 8'd1);
        cmp("codechg_code", {6'd0, pcodes.size() > 0 ? pcodes[0] : 2'b00}, 8'd3);

        // Release bounce: no second pulse, held survives short gaps.
        quiet(10);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b10001);
        for (int i = 0; i < 8; i++) step(1'b0, (i % 2 == 0) ? 5'b0 : 5'b10001);
        for (int i = 0; i < 3; i++) step(1'b0, 5'b0);
        cmp("relbounce_held_mid", {7'd0, buttonHeld}, 8'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b0);
        cmp("relbounce_pulses", 8'(pcount), 8'd1);
        cmp("relbounce_held_end", {7'd0, buttonHeld}, 8'd0);

        // Reset during ARMING, then during HELD.
        quiet(4);
        for (int i = 0; i < 3; i++) step(1'b0, 5'b10001);
        reset_then_press("rst_arming");
        for (int i = 0; i < 4; i++) step(1'b0, 5'b10001);
        reset_then_press("rst_held");

        // Back-to-back presses.
        quiet(12);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b10000);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b10011);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b0);
        cmp("b2b_pulses", 8'(pcount), 8'd2);
        cmp("b2b_code0", {6'd0, pcodes.size() > 0 ? pcodes[0] : 2'b11}, 8'd0);
        cmp("b2b_code1", {6'd0, pcodes.size() > 1 ? pcodes[1] : 2'b00}, 8'd3);

        // Random segments of held values with occasional resets.
        for (int s = 0; s < 400; s++) begin
            v = ($urandom_range(0, 2) == 0) ? 5'b0 : {1'b1, 2'($urandom), 2'($urandom)};
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) step($urandom_range(0, 150) == 0, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
